// File: rtl/bubble_sort_if.sv
// bubble_sort_if: control, load and display bundle for bubble_sort_engine; BUBBLE_SORT_STEP_EN adds step pacing
interface bubble_sort_if #(
  parameter int N = 5,
  parameter int W = 7,
  parameter int IDXW = 4
);
  logic tick, start, shuffle, load_we;
  logic [IDXW-1:0] load_idx;
  logic [W-1:0] load_data;
  logic [N*W-1:0] heights;
  logic [IDXW-1:0] cmp_idx;
  logic swapping, busy, done;
  logic [15:0] swap_count;
`ifdef BUBBLE_SORT_STEP_EN
  logic step_mode, step;
  modport master (
    output tick, start, shuffle, load_we, load_idx, load_data, step_mode, step,
    input heights, cmp_idx, swapping, busy, done, swap_count
  );
  modport slave (
    input tick, start, shuffle, load_we, load_idx, load_data, step_mode, step,
    output heights, cmp_idx, swapping, busy, done, swap_count
  );
`else
  modport master (
    output tick, start, shuffle, load_we, load_idx, load_data,
    input heights, cmp_idx, swapping, busy, done, swap_count
  );
  modport slave (
    input tick, start, shuffle, load_we, load_idx, load_data,
    output heights, cmp_idx, swapping, busy, done, swap_count
  );
`endif
endinterface

// File: rtl/bubble_sort_engine.sv
// bubble_sort_engine: paced in-place bubble sort with LFSR shuffle, direct load and early exit.
// Optional macro BUBBLE_SORT_STEP_EN adds step_mode/step pacing alongside tick.
module bubble_sort_engine #(
  parameter int N = 5,
  parameter int W = 7,
  parameter int MAX_H = 63,
  parameter int INIT_STEP = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int IDXW = 4
) (
  input logic clk,
  input logic reset,
  bubble_sort_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam logic [W-1:0] MAXV = W'(MAX_H);
  localparam logic [IDXW-1:0] LASTP = IDXW'(N - 2);
  typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] heights_q [N];
  logic [W-1:0] heights_d [N];
  logic [15:0] lfsr_q, lfsr_d, sc_q, sc_d;
  logic [AW-1:0] k_q, k_d, ja, jb;
  logic [IDXW-1:0] p_q, p_d, j_q, j_d, last_j;
  logic ps_q, ps_d, ps_eff, adv, go;
  logic swapping_q, busy_q, done_q;
  logic [W-1:0] raw, rnd;
`ifdef BUBBLE_SORT_STEP_EN
  assign go = bus.step_mode ? bus.step : bus.tick;
`else
  assign go = bus.tick;
`endif
  assign ja = j_q[AW-1:0];
  assign jb = ja + 1'b1;
  assign last_j = LASTP - p_q;
  assign raw = lfsr_q[W-1:0];
  assign rnd = (raw > MAXV) ? MAXV : (raw == '0) ? W'(1) : raw;
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  always_comb begin
    state_d = state_q;
    heights_d = heights_q;
    k_d = k_q;
    p_d = p_q;
    j_d = j_q;
    ps_d = ps_q;
    sc_d = sc_q;
    ps_eff = ps_q;
    adv = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.shuffle) begin
          heights_d[k_q] = rnd;
          k_d = (k_q == AW'(N - 1)) ? '0 : k_q + 1'b1;
          state_d = IDLE;
        end else if (bus.load_we) begin
          if (int'(bus.load_idx) < N) heights_d[bus.load_idx[AW-1:0]] = bus.load_data;
          state_d = IDLE;
        end else if (bus.start) begin
          p_d = '0;
          j_d = '0;
          ps_d = 1'b0;
          sc_d = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (go) begin
          if (heights_q[ja] > heights_q[jb]) state_d = SWAP;
          else adv = 1'b1;
        end
      end
      SWAP: begin
        if (go) begin
          heights_d[ja] = heights_q[jb];
          heights_d[jb] = heights_q[ja];
          sc_d = (&sc_q) ? sc_q : sc_q + 1'b1;
          ps_eff = 1'b1;
          adv = 1'b1;
        end
      end
    endcase
    // a pass ends when j reaches N-2-p; a clean pass or the last pass finishes the sort
    if (adv) begin
      if (j_q < last_j) begin
        j_d = j_q + 1'b1;
        ps_d = ps_eff;
        state_d = COMPARE;
      end else if (!ps_eff || p_q == LASTP) begin
        j_d = '0;
        ps_d = ps_eff;
        state_d = DONE;
      end else begin
        p_d = p_q + 1'b1;
        j_d = '0;
        ps_d = 1'b0;
        state_d = COMPARE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      k_q <= '0;
      p_q <= '0;
      j_q <= '0;
      ps_q <= 1'b0;
      sc_q <= '0;
      swapping_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < N; i++) heights_q[i] <= W'((i + 1) * INIT_STEP);
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      k_q <= k_d;
      p_q <= p_d;
      j_q <= j_d;
      ps_q <= ps_d;
      sc_q <= sc_d;
      swapping_q <= state_d == SWAP;
      busy_q <= state_d == COMPARE || state_d == SWAP;
      done_q <= state_d == DONE;
      heights_q <= heights_d;
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.heights[g*W +: W] = heights_q[g];
  end
  assign bus.cmp_idx = j_q;
  assign bus.swapping = swapping_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.swap_count = sc_q;
endmodule

// File: tb/tb_bubble_sort_engine.sv
// tb_bubble_sort_engine: table-driven and randomized checks of bubble_sort_engine against a plain-arithmetic model
module tb_bubble_sort_engine;
  localparam int N = 5;
  localparam int W = 7;
  localparam int IDXW = 4;
  typedef logic [N-1:0][W-1:0] arr_t;
  typedef struct {
    arr_t a;
    arr_t s;
    int sw;
    int tk;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] m_lfsr;
  int total = 0;
  int bad = 0;
  vec_t tbl [6];
  arr_t ramp;
  bubble_sort_if #(.N(N), .W(W), .IDXW(IDXW)) bus ();
  bubble_sort_engine dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic arr_t mk(input int v0, input int v1, input int v2, input int v3, input int v4);
    arr_t r;
    r[0] = W'(v0); r[1] = W'(v1); r[2] = W'(v2); r[3] = W'(v3); r[4] = W'(v4);
    return r;
  endfunction

  function automatic logic [W-1:0] clampv(input logic [W-1:0] v);
    return (v > 63) ? W'(63) : (v == 0) ? W'(1) : v;
  endfunction

  // sorted result from a queue sort, swaps as inversion count, ticks as compares plus swaps per pass
  function automatic void model(input arr_t a, output arr_t s, output int sw, output int tk);
    int q[$];
    int v[N];
    sw = 0;
    tk = 0;
    for (int i = 0; i < N; i++) begin
      q.push_back(int'(a[i]));
      v[i] = int'(a[i]);
    end
    q.sort();
    for (int i = 0; i < N; i++) s[i] = W'(q[i]);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (a[i] > a[j]) sw++;
    for (int p = 0; p < N - 1; p++) begin
      int moved = 0;
      for (int j = 0; j < N - 1 - p; j++) begin
        tk++;
        if (v[j] > v[j+1]) begin
          int t = v[j];
          v[j] = v[j+1];
          v[j+1] = t;
          tk++;
          moved++;
        end
      end
      if (moved == 0) break;
    end
  endfunction

  task automatic pace(input bit use_step);
`ifdef BUBBLE_SORT_STEP_EN
    if (use_step) bus.step = 1'b1;
    else bus.tick = 1'b1;
    clk1();
    bus.step = 1'b0;
`else
    if (use_step) $display("step pacing unavailable in this build");
    bus.tick = 1'b1;
    clk1();
`endif
    bus.tick = 1'b0;
  endtask

  task automatic load_arr(input arr_t a);
    for (int i = 0; i < N; i++) begin
      bus.load_we = 1'b1;
      bus.load_idx = IDXW'(i);
      bus.load_data = a[i];
      clk1();
    end
    bus.load_we = 1'b0;
  endtask

  task automatic finish_sort(input string nm, input arr_t s, input int sw, input int tk, input bit use_step);
    int n = 0;
    while (!bus.done && n < 300) begin
      pace(use_step);
      n++;
      if (!bus.done) clk1();
    end
    chk({nm, "/ticks"}, 64'(n), 64'(tk));
    chk({nm, "/heights"}, 64'(bus.heights), 64'(s));
    chk({nm, "/swap_count"}, 64'(bus.swap_count), 64'(sw));
    chk({nm, "/busy_end"}, 64'(bus.busy), 64'(0));
    chk({nm, "/done_end"}, 64'(bus.done), 64'(1));
    chk({nm, "/cmp_end"}, 64'(bus.cmp_idx), 64'(0));
  endtask

  task automatic run_sort(input string nm, input arr_t a, input arr_t s, input int sw, input int tk, input bit use_step);
    load_arr(a);
    chk({nm, "/loaded"}, 64'(bus.heights), 64'(a));
    bus.start = 1'b1;
    bus.tick = 1'b1;
    clk1();
    bus.start = 1'b0;
    bus.tick = 1'b0;
    chk({nm, "/start_busy"}, 64'(bus.busy), 64'(1));
    chk({nm, "/start_cmp"}, 64'({bus.cmp_idx, bus.swapping}), 64'(0));
    finish_sort(nm, s, sw, tk, use_step);
  endtask

  initial begin
    arr_t exp_a, s;
    int sw, tk, mk_i;
    logic [W-1:0] v;
    tbl[0] = '{mk(50,10,40,20,30), mk(10,20,30,40,50), 6, 15};
    tbl[1] = '{mk(10,20,30,40,50), mk(10,20,30,40,50), 0, 4};
    tbl[2] = '{mk(50,40,30,20,10), mk(10,20,30,40,50), 10, 20};
    tbl[3] = '{mk(30,30,10,20,40), mk(10,20,30,30,40), 4, 13};
    tbl[4] = '{mk(1,1,1,1,1), mk(1,1,1,1,1), 0, 4};
    tbl[5] = '{mk(63,0,127,5,5), mk(0,5,5,63,127), 5, 14};
    ramp = mk(10,20,30,40,50);
    bus.tick = 0; bus.start = 0; bus.shuffle = 0; bus.load_we = 0;
    bus.load_idx = '0; bus.load_data = '0;
`ifdef BUBBLE_SORT_STEP_EN
    bus.step_mode = 0; bus.step = 0;
`endif
    reset = 1'b1;
    clk1();
    clk1();
    reset = 1'b0;
    chk("rst/heights", 64'(bus.heights), 64'(ramp));
    chk("rst/flags", 64'({bus.done, bus.busy, bus.swapping}), 64'(0));
    chk("rst/swap_count", 64'(bus.swap_count), 64'(0));
    chk("rst/cmp_idx", 64'(bus.cmp_idx), 64'(0));
    repeat (3) pace(0);
    chk("idle_ticks/heights", 64'(bus.heights), 64'(ramp));
    chk("idle_ticks/busy", 64'(bus.busy), 64'(0));
    bus.load_we = 1'b1; bus.load_data = 7'd99;
    bus.load_idx = 4'd5; clk1();
    bus.load_idx = 4'd15; clk1();
    bus.load_we = 1'b0;
    chk("oob_load", 64'(bus.heights), 64'(ramp));
    for (int i = 0; i < 6; i++) run_sort($sformatf("vec%0d", i), tbl[i].a, tbl[i].s, tbl[i].sw, tbl[i].tk, 1'b0);
    repeat (6) begin
      for (int i = 0; i < N; i++) exp_a[i] = W'($urandom_range(0, 127));
      model(exp_a, s, sw, tk);
      run_sort("rand", exp_a, s, sw, tk, 1'b0);
    end
    // equal pair kept, then 30/10 swapped; busy ignores load/shuffle; reset on tick 3
    load_arr(tbl[3].a);
    bus.start = 1'b1; clk1(); bus.start = 1'b0;
    chk("eq/cmp0", 64'({bus.cmp_idx, bus.swapping}), 64'({4'd0, 1'b0}));
    clk1();
    clk1();
    chk("eq/hold", 64'({bus.cmp_idx, bus.busy}), 64'({4'd0, 1'b1}));
    pace(0);
    chk("eq/cmp1", 64'({bus.cmp_idx, bus.swapping}), 64'({4'd1, 1'b0}));
    pace(0);
    chk("eq/cmp1_swap", 64'({bus.cmp_idx, bus.swapping}), 64'({4'd1, 1'b1}));
    bus.load_we = 1'b1; bus.load_idx = 4'd0; bus.load_data = 7'd99; bus.shuffle = 1'b1;
    clk1();
    clk1();
    bus.load_we = 1'b0; bus.shuffle = 1'b0;
    chk("busy_ignore/heights", 64'(bus.heights), 64'(tbl[3].a));
    chk("busy_ignore/state", 64'({bus.busy, bus.swapping}), 64'(2'b11));
    reset = 1'b1; bus.tick = 1'b1;
    clk1();
    reset = 1'b0; bus.tick = 1'b0;
    chk("midrst/heights", 64'(bus.heights), 64'(ramp));
    chk("midrst/flags", 64'({bus.done, bus.busy, bus.swapping, bus.cmp_idx}), 64'(0));
    // shuffle from a fresh seed with the round-robin pointer at 0
    exp_a = ramp;
    mk_i = 0;
    bus.shuffle = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      v = clampv(m_lfsr[W-1:0]);
      exp_a[mk_i] = v;
      clk1();
      chk($sformatf("shuf/c%0d", c), 64'(bus.heights[mk_i*W +: W]), 64'(v));
      if (v < 1 || v > 63) chk("shuf/range", 64'(v), 64'(0));
      mk_i = (mk_i + 1) % N;
    end
    bus.shuffle = 1'b0;
    chk("shuf/all", 64'(bus.heights), 64'(exp_a));
    bus.start = 1'b1; clk1(); bus.start = 1'b0;
    bus.shuffle = 1'b1; bus.load_we = 1'b1; bus.load_idx = 4'd2; bus.load_data = 7'd5;
    repeat (3) clk1();
    bus.shuffle = 1'b0; bus.load_we = 1'b0;
    chk("shuf_busy/heights", 64'(bus.heights), 64'(exp_a));
    model(exp_a, s, sw, tk);
    finish_sort("shuf_sort", s, sw, tk, 1'b0);
`ifdef BUBBLE_SORT_STEP_EN
    load_arr(tbl[0].a);
    bus.step_mode = 1'b1;
    bus.start = 1'b1; clk1(); bus.start = 1'b0;
    repeat (20) pace(0);
    chk("step/no_tick_progress", 64'({bus.cmp_idx, bus.swapping, bus.busy}), 64'({4'd0, 1'b0, 1'b1}));
    chk("step/no_tick_heights", 64'(bus.heights), 64'(tbl[0].a));
    pace(1);
    chk("step/one_step", 64'({bus.cmp_idx, bus.swapping}), 64'({4'd0, 1'b1}));
    finish_sort("step", tbl[0].s, 6, 14, 1'b1);
    bus.step_mode = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
